// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Module  : shift_sequencer_if
// Brief   : Start/busy/done handshake and data bundle for shift_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output start, op, in, cnt,
        input  busy, done, out
    );

    modport slave (
        input  start, op, in, cnt,
        output busy, done, out
    );
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module  : shift_sequencer
// Brief   : Multi-cycle ROL/SLL/ROR/SRA sequencer stepping 1 or 2 positions
//           per cycle (4 as well when SHIFT_SEQ_FAST4_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    shift_sequencer_if.slave bus
);

    localparam logic [1:0] c_OP_ROL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_ROR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_rem;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_out;

    logic             w_accept;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] w_acc_next;

    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] a,
        input logic [1:0]       o,
        input logic [CNT_W-1:0] k
    );
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        dbl = {a, a};
        case (o)
            c_OP_ROL: begin
                dbl = dbl << k;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            c_OP_SLL: res = a << k;
            c_OP_ROR: begin
                dbl = dbl >> k;
                res = dbl[WIDTH-1:0];
            end
            default:  res = $unsigned($signed(a) >>> k);
        endcase
        return res;
    endfunction

    // start only matters when the sequencer is not mid-shift
    assign w_accept = bus.start && (r_state != ST_SHIFT);

    // Largest step that does not overshoot the remaining count
    always_comb begin
        w_step = CNT_W'(1);
`ifdef SHIFT_SEQ_FAST4_EN
        if (r_rem >= CNT_W'(4)) begin
            w_step = CNT_W'(4);
        end else if (r_rem >= CNT_W'(2)) begin
            w_step = CNT_W'(2);
        end
`else
        if (r_rem >= CNT_W'(2)) begin
            w_step = CNT_W'(2);
        end
`endif
    end

    assign w_rem_next = r_rem - w_step;
    assign w_acc_next = f_shift(r_acc, r_op, w_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = (bus.cnt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_op  <= '0;
            r_out <= '0;
        end else if (w_accept) begin
            r_acc <= bus.in;
            r_rem <= bus.cnt;
            r_op  <= bus.op;
            if (bus.cnt == '0) begin
                r_out <= bus.in;
            end
        end else if (r_state == ST_SHIFT) begin
            r_acc <= w_acc_next;
            r_rem <= w_rem_next;
            // Only the final step is published; partial results stay internal
            if (w_rem_next == '0) begin
                r_out <= w_acc_next;
            end
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.out  = r_out;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module  : tb_shift_sequencer
// Brief   : Directed self-checking bench with a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    shift_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus_if ();

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of the complete shift by n positions at once
    function automatic int full_shift(input int x, input int o, input int n);
        int r;
        case (o)
            0: r = ((x << n) | (x >> (16 - n))) & 32'hFFFF;
            1: r = (x << n) & 32'hFFFF;
            2: r = ((x >> n) | (x << (16 - n))) & 32'hFFFF;
            default: begin
                r = x >> n;
                if (x[15]) r = r | (~(32'hFFFF >> n) & 32'hFFFF);
            end
        endcase
        return r;
    endfunction

    function automatic int steps(input int n);
`ifdef SHIFT_SEQ_FAST4_EN
        return n / 4 + (n % 4) / 2 + n % 2;
`else
        return (n + 1) / 2;
`endif
    endfunction

    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [15:0] exp_out  = 16'h0;
    logic [15:0] m_res    = 16'h0;
    int          m_left   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_out  <= 16'h0;
            m_left   <= 0;
        end else if (bus_if.start && !exp_busy) begin
            if (steps(int'(bus_if.cnt)) == 0) begin
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
                exp_out  <= 16'(full_shift(int'(bus_if.in), int'(bus_if.op), int'(bus_if.cnt)));
            end else begin
                exp_busy <= 1'b1;
                exp_done <= 1'b0;
                m_left   <= steps(int'(bus_if.cnt));
                m_res    <= 16'(full_shift(int'(bus_if.in), int'(bus_if.op), int'(bus_if.cnt)));
            end
        end else if (exp_busy) begin
            if (m_left == 1) begin
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
                exp_out  <= m_res;
            end
            m_left <= m_left - 1;
        end else begin
            exp_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", int'(bus_if.busy), int'(exp_busy));
        check("done", int'(bus_if.done), int'(exp_done));
        check("out",  int'(bus_if.out),  int'(exp_out));
        check("busy_done_excl", int'(bus_if.busy & bus_if.done), 0);
    end

    // Issue one request and pin result and latency against hand-computed values
    task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] x,
                          input logic [3:0] n, input int exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = o;
        bus_if.in    = x;
        bus_if.cnt   = n;
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = 0;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, int'(bus_if.out), exp_res);
    endtask

    initial begin
        int lat;
        int pulses;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.in    = 16'h0;
        bus_if.cnt   = 4'h0;
        #1;
        check("reset_busy", int'(bus_if.busy), 0);
        check("reset_done", int'(bus_if.done), 0);
        check("reset_out",  int'(bus_if.out),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("sra3",  2'b11, 16'h8000, 4'd3,  32'hF000, 2);
        run_op("rol1",  2'b00, 16'h8001, 4'd1,  32'h0003, 1);
        run_op("sll0",  2'b01, 16'h1234, 4'd0,  32'h1234, 0);
`ifdef SHIFT_SEQ_FAST4_EN
        run_op("ror15", 2'b10, 16'h0001, 4'd15, 32'h0002, 5);
`else
        run_op("ror15", 2'b10, 16'h0001, 4'd15, 32'h0002, 8);
`endif
        run_op("sra_pos", 2'b11, 16'h7F00, 4'd6, 32'h01FC, steps(6));

        // Busy lockout: second start during SHIFT must be ignored
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 2'b01; bus_if.in = 16'h00FF; bus_if.cnt = 4'd8;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.in = 16'hFFFF; bus_if.cnt = 4'd1;
        @(negedge clk);
        bus_if.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.done) begin
                pulses++;
                check("lockout_result", int'(bus_if.out), 32'hFF00);
            end
            @(negedge clk);
        end
        check("lockout_done_pulses", pulses, 1);

        // Back-to-back: next start held during the DONE cycle
        bus_if.start = 1'b1; bus_if.op = 2'b01; bus_if.in = 16'h0001; bus_if.cnt = 4'd4;
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = 0;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_result", int'(bus_if.out), 32'h0010);
        bus_if.start = 1'b1; bus_if.op = 2'b11; bus_if.in = 16'hF000; bus_if.cnt = 4'd2;
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = 0;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 1);
        check("b2b_second_result", int'(bus_if.out), 32'hFC00);

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.in = 16'h1234; bus_if.cnt = 4'd9;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(posedge clk);
        #3;
        check("pre_reset_busy", int'(bus_if.busy), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", int'(bus_if.busy), 0);
        check("async_reset_done", int'(bus_if.done), 0);
        check("async_reset_out",  int'(bus_if.out),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.done) pulses++;
        end
        check("post_reset_no_done", pulses, 0);
        run_op("post_reset_rol", 2'b00, 16'h8001, 4'd1, 32'h0003, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift/rotate controller for the 16-bit execute stage. It sequences one internal shift step, either 1 or 2 positions per cycle, over as many cycles as the count requires. This gives the ALU a full 0-15 position shift without a full barrel shifter. Simple start/busy/done handshake toward the execute-stage control.

Parameters:
WIDTH, 16, operand/result width in bits; only 16 is supported.
CNT_W, 4, shift count width; the count ranges 0..2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only while busy=0.
op  input  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
in  input  WIDTH  operand; sampled with start.
cnt  input  CNT_W  shift amount; sampled with start.
busy  output  1  high while a shift is in progress.
done  output  1  one-cycle pulse when out is valid.
out  output  WIDTH  result register; holds until the next completion or reset.

Behaviour:
- Reset: asynchronous on rst_n=0, which forces state=IDLE, out=0, busy=0, done=0, internal acc=0 and rem=0. Reset applies immediately, including mid-operation. The aborted operation produces no done pulse.
- States:
  - IDLE: waiting for a request.
  - SHIFT: busy=1, one step per edge.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Accept rule: start is accepted on a rising edge when the state is IDLE or DONE, i.e. busy=0.
  - Back-to-back requests issued during the DONE cycle are accepted.
  - start is ignored while in SHIFT. The in, op and cnt inputs are don't-care when no start is accepted.
- On accept: acc<=in, rem<=cnt, op latched.
  - cnt=0: go directly to DONE.
  - cnt≠0: go to SHIFT.
- SHIFT step, one per edge:
  - rem>=2: acc shifted 2 positions, rem-=2.
  - rem==1: acc shifted 1 position, rem-=1.
  - When the new rem is 0: out<=acc_next and go to DONE.
- Step semantics for k positions:
  - ROL: bits leaving the MSB re-enter at the LSB.
  - SLL: zeros fill the LSBs.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - SRA: acc[15] is replicated into the top k bits.
- out is updated only on the final step, or on accept when cnt=0 (out<=in). It never shows partial results.
- Latency: done is high in the cycle after edge e0+S.
  - e0 is the accepting edge.
  - S = ceil(cnt/2); S=0 for cnt=0.
  - busy is high for exactly S cycles; it is never high for cnt=0.
- done and busy are never high together.
- rem never underflows; the step size is chosen from rem.

Optional Feature:
Macro: SHIFT_SEQ_FAST4_EN.
- Defined: adds a 4-position step.
  - Per edge, the step is 4 if rem>=4, else 2 if rem>=2, else 1.
  - S = floor(cnt/4) + floor((cnt mod 4)/2) + (cnt mod 2).
  - Example: cnt=15 takes 5 steps (4,4,4,2,1).
- Undefined: only 1- and 2-position steps exist; cnt=15 takes 8 steps.
- The result value is identical in both builds; only latency differs.

Test Plan:
- SRA: op=11, in=0x8000, cnt=3 -> out=0xF000. busy high 2 cycles, done after e0+2, in both builds.
- ROL: op=00, in=0x8001, cnt=1 -> out=0x0003, done after e0+1. SLL: in=0x1234, cnt=0 -> out=0x1234, done after e0, busy never asserted.
- ROR: op=10, in=0x0001, cnt=15 -> out=0x0002. done after e0+8 without SHIFT_SEQ_FAST4_EN, after e0+5 with it.
- Busy lockout: SLL in=0x00FF cnt=8 accepted, then start with in=0xFFFF cnt=1 pulsed during SHIFT -> ignored. Result out=0xFF00 with a single done pulse.
- Back-to-back: start held during the DONE cycle of the previous op (SLL 0x0001 cnt=4 -> 0x0010) with new op=11, in=0xF000, cnt=2 -> accepted, second result 0xFC00.
- Reset: rst_n driven low mid-SHIFT of ROL 0x1234 cnt=9 -> out=0, busy=0, done=0 immediately, without waiting for a clock. After release: IDLE, no stray done, next start behaves normally.
